siren_driver: RTL

//   Downstream of the alarm FSM in top. Takes the FSM's set and alarm-active indications.

---
 rtl/siren_driver.sv | 117 +++++++++++
 1 files changed

// File: rtl/siren_driver.sv
// siren_driver: timed RGB siren pattern and armed-status LED blink, driven
// from level set/alarm indications. Includes its own tick prescaler.
module siren_driver #(
  parameter int TICK_DIV     = 4,
  parameter int COLOR_HOLD   = 2,
  parameter int BLINK_PERIOD = 4,
  parameter int BLINK_ON     = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set,
  input  logic       alarm,
  output logic [2:0] siren,
  output logic       status_led
);

  localparam int CNT_W   = $clog2(TICK_DIV);
  localparam int HOLD_W  = (COLOR_HOLD > 1) ? $clog2(COLOR_HOLD) : 1;
  localparam int BLINK_W = $clog2(BLINK_PERIOD);

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(COLOR_HOLD - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIOD - 1);
  localparam logic [BLINK_W-1:0] BLINK_LIT = BLINK_W'(BLINK_ON);

  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_WHITE = 3'b111;

  typedef enum logic [1:0] {IDLE, ARMED, ALARM} state_t;
  typedef enum logic [1:0] {C_RED, C_BLUE, C_WHITE} color_t;

  state_t              state_q, state_d;
  color_t              col_q, col_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic [2:0]          siren_d;
  logic                led_d;
  logic                tick;

  assign tick = (cnt_q == CNT_MAX);

  // Register state, counters and outputs together so outputs lag inputs by one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= C_RED;
      cnt_q      <= '0;
      hold_q     <= '0;
      blink_q    <= '0;
      siren      <= 3'b000;
      status_led <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      blink_q    <= blink_d;
      siren      <= siren_d;
      status_led <= led_d;
    end
  end

  // Next state, counter updates and next output values; evaluated every clock.
  always_comb begin
    state_d = state_q;
    col_d   = C_RED;
    cnt_d   = cnt_q;
    hold_d  = '0;
    blink_d = '0;
    siren_d = 3'b000;
    led_d   = 1'b0;

    if (alarm)    state_d = ALARM;
    else if (set) state_d = ARMED;
    else          state_d = IDLE;

    // Prescaler restarts on any state change so every state begins a full tick.
    if ((state_d != state_q) || tick) cnt_d = '0;
    else                              cnt_d = cnt_q + 1'b1;

    case (state_d)
      ARMED: begin
        if (state_q != ARMED) blink_d = '0;
        else if (tick)        blink_d = (blink_q == BLINK_MAX) ? '0 : blink_q + 1'b1;
        else                  blink_d = blink_q;
        led_d = (blink_d < BLINK_LIT);
      end
      ALARM: begin
        led_d = 1'b1;
        if (state_q != ALARM) begin
          col_d  = C_RED;
          hold_d = '0;
        end else if (tick && (hold_q == HOLD_MAX)) begin
          hold_d = '0;
          case (col_q)
            C_RED:   col_d = C_BLUE;
            C_BLUE:  col_d = C_WHITE;
            default: col_d = C_RED;
          endcase
        end else begin
          col_d  = col_q;
          hold_d = tick ? hold_q + 1'b1 : hold_q;
        end
        case (col_d)
          C_RED:   siren_d = RGB_RED;
          C_BLUE:  siren_d = RGB_BLUE;
          C_WHITE: siren_d = RGB_WHITE;
          default: siren_d = RGB_RED;
        endcase
      end
      default: ;
    endcase
  end

endmodule
